// File: rtl/mceliece_encrypt_if.sv
// Handshake bundle for the streaming McEliece encryptor: start/message,
// error-position stream, public-key column stream and ciphertext word stream.
interface mceliece_encrypt_if #(
  parameter int N = 361,
  parameter int K = 741,
  parameter int W = 32
) ();
  localparam int PW = $clog2(K);

  logic          start;
  logic [N-1:0]  msg;
  logic [PW-1:0] err_pos;
  logic          err_pos_valid;
  logic          err_pos_ready;
  logic [N-1:0]  key_col;
  logic          key_col_valid;
  logic          key_col_ready;
  logic [W-1:0]  ct_word;
  logic          ct_valid;
  logic          ct_ready;
  logic          ct_last;
  logic          busy;
  logic          done;
  logic          err_fault;

  modport master (
    output start, msg, err_pos, err_pos_valid, key_col, key_col_valid, ct_ready,
    input  err_pos_ready, key_col_ready, ct_word, ct_valid, ct_last, busy, done, err_fault
  );

  modport slave (
    input  start, msg, err_pos, err_pos_valid, key_col, key_col_valid, ct_ready,
    output err_pos_ready, key_col_ready, ct_word, ct_valid, ct_last, busy, done, err_fault
  );
endinterface

// File: rtl/mceliece_encrypt.sv
// Streaming McEliece encryptor: c = m*G' xor e. One public-key column is
// consumed per accepted handshake; ciphertext bits are packed into W-bit words
// and emitted with valid/ready backpressure.
// Optional macro ENC_ERR_CHECK_EN enables the sticky error-vector fault flag
// (out-of-range or duplicate error positions); otherwise err_fault is tied low.
module mceliece_encrypt #(
  parameter int Q = 19,
  parameter int T = 10,
  parameter int N = Q * Q,
  parameter int K = N + 2 * T * Q,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  mceliece_encrypt_if.slave bus
);
  localparam int PW = $clog2(K);
  localparam int BW = $clog2(W);
  localparam int CW = $clog2(T + 1);
  localparam logic [PW:0]   K_P    = (PW + 1)'(K);
  localparam logic [PW-1:0] J_LAST = PW'(K - 1);
  localparam logic [BW-1:0] B_LAST = BW'(W - 1);
  localparam logic [CW-1:0] C_LAST = CW'(T - 1);

  typedef enum logic [1:0] {IDLE, ERR, ENC, DRAIN} state_t;

  state_t        state;
  logic [N-1:0]  msg_r;
  logic [K-1:0]  e_r;
  logic [PW-1:0] j;
  logic [BW-1:0] bit_idx;
  logic [CW-1:0] err_cnt;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_nx;
  logic          cbit;
  logic          col_fire;
  logic          word_end;
  logic          pos_ok;

  assign pos_ok   = {1'b0, bus.err_pos} < K_P;
  assign col_fire = (state == ENC) && bus.key_col_valid && bus.key_col_ready;
  assign word_end = (bit_idx == B_LAST) || (j == J_LAST);
  assign cbit     = (^(msg_r & bus.key_col)) ^ e_r[j];

  assign bus.err_pos_ready = (state == ERR);
  assign bus.key_col_ready = (state == ENC) && !(bus.ct_valid && !bus.ct_ready);
  assign bus.busy          = (state != IDLE);

  // Accumulator with the current column's ciphertext bit merged in
  always_comb begin
    acc_nx          = acc;
    acc_nx[bit_idx] = cbit;
  end

  // Control FSM, error register, column accumulation and output word register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      msg_r       <= '0;
      e_r         <= '0;
      j           <= '0;
      bit_idx     <= '0;
      err_cnt     <= '0;
      acc         <= '0;
      bus.ct_word <= '0;
      bus.ct_valid <= 1'b0;
      bus.ct_last <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            msg_r   <= bus.msg;
            e_r     <= '0;
            j       <= '0;
            bit_idx <= '0;
            err_cnt <= '0;
            acc     <= '0;
            state   <= ERR;
          end
        end
        ERR: begin
          if (bus.err_pos_valid) begin
            if (pos_ok) e_r[bus.err_pos] <= 1'b1;
            if (err_cnt == C_LAST) state <= ENC;
            else err_cnt <= err_cnt + 1'b1;
          end
        end
        ENC: begin
          if (bus.ct_valid && bus.ct_ready) bus.ct_valid <= 1'b0;
          if (col_fire) begin
            if (word_end) begin
              // completed word replaces any word handed off on this same edge
              bus.ct_word  <= acc_nx;
              bus.ct_valid <= 1'b1;
              bus.ct_last  <= (j == J_LAST);
              acc          <= '0;
              bit_idx      <= '0;
              if (j == J_LAST) state <= DRAIN;
              else j <= j + 1'b1;
            end else begin
              acc     <= acc_nx;
              bit_idx <= bit_idx + 1'b1;
              j       <= j + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.ct_valid && bus.ct_ready) begin
            bus.ct_valid <= 1'b0;
            bus.ct_last  <= 1'b0;
            bus.done     <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ENC_ERR_CHECK_EN
  logic fault_q;

  // Sticky fault: error position out of range or hitting an already-set bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      fault_q <= 1'b0;
    end else if (state == ERR && bus.err_pos_valid && (!pos_ok || e_r[bus.err_pos])) begin
      fault_q <= 1'b1;
    end
  end

  assign bus.err_fault = fault_q;
`else
  assign bus.err_fault = 1'b0;
`endif

endmodule
